// File: rtl/uart_setpoint_rx.sv
// uart_setpoint_rx
//   UART receiver (8N1) plus ASCII line parser that supplies the d/q current
//   setpoints to foc_controller. Accepted lines are "D<int>\n" or "Q<int>\n",
//   where <int> is signed decimal; '\r' is ignored everywhere. Each committed
//   value is clamped to [-LIMIT, +LIMIT].
//
// Parameters
//   CLK_DIV  clock cycles per UART bit (347 = 40 MHz / 115200)
//   LIMIT    magnitude clamp applied to every accepted setpoint
//
// Ports
//   I_clk_40m     in   1   system clock
//   I_rst         in   1   synchronous reset, active-high
//   I_uart_rx     in   1   UART RX line, idle high, asynchronous to clock
//   O_id_aim      out  16  signed d-axis current setpoint
//   O_iq_aim      out  16  signed q-axis current setpoint
//   O_aim_update  out  1   1-cycle pulse when O_id_aim or O_iq_aim is written
//   O_cmd_err     out  1   1-cycle pulse on a rejected line or a framing error
module uart_setpoint_rx #(
  parameter logic [15:0] CLK_DIV = 16'd347,
  parameter logic [15:0] LIMIT   = 16'd2000
) (
  input  logic               I_clk_40m,
  input  logic               I_rst,
  input  logic               I_uart_rx,
  output logic signed [15:0] O_id_aim,
  output logic signed [15:0] O_iq_aim,
  output logic               O_aim_update,
  output logic               O_cmd_err
);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_CMD, P_SIGN, P_DIGIT, P_SKIP} p_state_t;

  localparam logic [7:0] CH_D     = 8'h44;
  localparam logic [7:0] CH_Q     = 8'h51;
  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;

  // ---------------------------------------------------------------------------
  // Input synchronizer; rx_prev gives the falling-edge reference.
  // ---------------------------------------------------------------------------
  logic rx_s1, rx_s2, rx_prev;

  always_ff @(posedge I_clk_40m) begin
    if (I_rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= I_uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_t   rx_state, rx_state_n;
  logic [15:0] bit_cnt, bit_cnt_n;
  logic [2:0]  bit_idx, bit_idx_n;
  logic [7:0]  shift, shift_n;
  logic        byte_valid, frame_err;

  always_ff @(posedge I_clk_40m) begin
    if (I_rst) begin
      rx_state <= R_IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      rx_state <= rx_state_n;
      bit_cnt  <= bit_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
    end
  end

  always_comb begin
    rx_state_n = rx_state;
    bit_cnt_n  = bit_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (rx_prev && !rx_s2) begin
          bit_cnt_n  = CLK_DIV >> 1;
          rx_state_n = R_START;
        end
      end
      R_START: begin
        if (bit_cnt == '0) begin
          if (!rx_s2) begin
            rx_state_n = R_DATA;
            bit_cnt_n  = CLK_DIV - 16'd1;
            bit_idx_n  = '0;
          end else begin
            rx_state_n = R_IDLE;
          end
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      R_DATA: begin
        if (bit_cnt == '0) begin
          shift_n   = {rx_s2, shift[7:1]};
          bit_cnt_n = CLK_DIV - 16'd1;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) rx_state_n = R_STOP;
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      R_STOP: begin
        if (bit_cnt == '0) begin
          // Straight back to idle at mid-stop so a back-to-back start edge is seen.
          rx_state_n = R_IDLE;
          if (rx_s2) byte_valid = 1'b1;
          else       frame_err  = 1'b1;
        end else begin
          bit_cnt_n = bit_cnt - 16'd1;
        end
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Parser FSM; consumes shift directly in the byte_valid cycle.
  // ---------------------------------------------------------------------------
  p_state_t    p_state, p_state_n;
  logic        tgt_q, tgt_q_n;
  logic        neg, neg_n;
  logic [16:0] acc, acc_n;
  logic [2:0]  ndig, ndig_n;
  logic        commit, err;
  logic        is_digit;
  logic [3:0]  digit;

  assign is_digit = (shift >= CH_0) && (shift <= CH_9);
  assign digit    = shift[3:0];

  always_ff @(posedge I_clk_40m) begin
    if (I_rst) begin
      p_state <= P_CMD;
      tgt_q   <= 1'b0;
      neg     <= 1'b0;
      acc     <= '0;
      ndig    <= '0;
    end else begin
      p_state <= p_state_n;
      tgt_q   <= tgt_q_n;
      neg     <= neg_n;
      acc     <= acc_n;
      ndig    <= ndig_n;
    end
  end

  always_comb begin
    p_state_n = p_state;
    tgt_q_n   = tgt_q;
    neg_n     = neg;
    acc_n     = acc;
    ndig_n    = ndig;
    commit    = 1'b0;
    err       = 1'b0;
    if (frame_err) begin
      p_state_n = P_SKIP;
      err       = 1'b1;
    end else if (byte_valid && shift != CH_CR) begin
      case (p_state)
        P_CMD: begin
          if (shift == CH_D || shift == CH_Q) begin
            tgt_q_n   = (shift == CH_Q);
            neg_n     = 1'b0;
            acc_n     = '0;
            ndig_n    = '0;
            p_state_n = P_SIGN;
          end else if (shift != CH_LF) begin
            err       = 1'b1;
            p_state_n = P_SKIP;
          end
        end
        P_SIGN: begin
          if (shift == CH_MINUS) begin
            neg_n     = 1'b1;
            p_state_n = P_DIGIT;
          end else if (is_digit) begin
            acc_n     = {13'd0, digit};
            ndig_n    = 3'd1;
            p_state_n = P_DIGIT;
          end else if (shift == CH_LF) begin
            err       = 1'b1;
            p_state_n = P_CMD;
          end else begin
            err       = 1'b1;
            p_state_n = P_SKIP;
          end
        end
        P_DIGIT: begin
          if (is_digit) begin
            if (ndig == 3'd5) begin
              err       = 1'b1;
              p_state_n = P_SKIP;
            end else begin
              acc_n  = acc * 17'd10 + {13'd0, digit};
              ndig_n = ndig + 3'd1;
            end
          end else if (shift == CH_LF) begin
            if (ndig != '0) commit = 1'b1;
            else            err    = 1'b1;
            p_state_n = P_CMD;
          end else begin
            err       = 1'b1;
            p_state_n = P_SKIP;
          end
        end
        P_SKIP: begin
          if (shift == CH_LF) p_state_n = P_CMD;
        end
        default: p_state_n = P_CMD;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Clamp, sign and register outputs.
  // ---------------------------------------------------------------------------
  logic        [15:0] mag;
  logic signed [15:0] mag_s, commit_val;

  always_comb begin
    mag        = (acc > {1'b0, LIMIT}) ? LIMIT : acc[15:0];
    mag_s      = signed'(mag);
    commit_val = neg ? -mag_s : mag_s;
  end

  always_ff @(posedge I_clk_40m) begin
    if (I_rst) begin
      O_id_aim     <= '0;
      O_iq_aim     <= '0;
      O_aim_update <= 1'b0;
      O_cmd_err    <= 1'b0;
    end else begin
      if (commit) begin
        if (tgt_q) O_iq_aim <= commit_val;
        else       O_id_aim <= commit_val;
      end
      O_aim_update <= commit;
      O_cmd_err    <= err;
    end
  end

endmodule
